// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-channel alarm editor.
// Contents: edit-state encoding, display nibble codes, field moduli,
// the mode-button state sequence and a binary to two-digit BCD helper.
package alarm_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_SET_HR  = 3'd2,
    S_SET_MIN = 3'd3,
    S_SET_EN  = 3'd4
  } state_e;

  localparam logic [3:0] SEP_NIBBLE   = 4'hE;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam int         HR_MOD       = 24;
  localparam int         MIN_MOD      = 60;

  // Order in which the mode button walks the editor.
  function automatic state_e next_mode(input state_e s);
    case (s)
      S_IDLE:    next_mode = S_SEL;
      S_SEL:     next_mode = S_SET_HR;
      S_SET_HR:  next_mode = S_SET_MIN;
      S_SET_MIN: next_mode = S_SET_EN;
      default:   next_mode = S_IDLE;
    endcase
  endfunction

  // Values are held in binary and always lie in 0..59, so both digits fit.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    bin2bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/alarm_set_multi_button_pulse.sv
// button_pulse: conditions one raw push button.
// A 2-FF synchroniser feeds a debouncer whose accepted level changes only
// after DEBOUNCE_MS consecutive synchronised samples disagree with it.
// A one-cycle pulse marks each accepted 0->1 transition.
// Ports:
//   clk_1khz  system clock
//   rst       asynchronous active-high reset
//   en_i      enable; when low everything holds and no pulse is produced
//   btn_i     raw button input
//   pulse_o   one-cycle pulse per accepted press
module button_pulse #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic en_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else if (en_i) begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        // Any agreeing sample restarts the stability run.
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      // Drop a pending pulse so nothing is replayed once enable returns.
      pulse_q <= 1'b0;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alarm_set_multi.sv
// alarm_set_multi: editor for NUM_ALARMS alarm times plus enable flags.
// Three buttons drive an IDLE/SEL/HR/MIN/EN editor; the field being
// edited blinks on the display.
// Ports:
//   clk_1khz       1 kHz system clock
//   rst            asynchronous active-high reset
//   en             block enable; when low all state holds
//   btn_mode       raw button, advances the edit state
//   btn_add        raw button, increments the edited field
//   btn_clr        raw button, zeroes the edited field
//   display_out    8 nibbles: hr_t hr_o E min_t min_o E sel en[sel]
//   alarm_bcd_out  per alarm {hr_t,hr_o,min_t,min_o}, alarm k at [16k+15:16k]
//   alarm_en_out   per-alarm enable flags
//   editing        high whenever the editor is not idle
module alarm_set_multi
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int BLINK_MS    = 300,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                    clk_1khz,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    btn_mode,
  input  logic                    btn_add,
  input  logic                    btn_clr,
  output logic [31:0]             display_out,
  output logic [16*NUM_ALARMS-1:0] alarm_bcd_out,
  output logic [NUM_ALARMS-1:0]   alarm_en_out,
  output logic                    editing
);

  localparam int IDX_W   = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic mode_pulse, add_pulse, clr_pulse;

  button_pulse #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_mode (
    .clk_1khz(clk_1khz), .rst(rst), .en_i(en), .btn_i(btn_mode), .pulse_o(mode_pulse)
  );
  button_pulse #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_add (
    .clk_1khz(clk_1khz), .rst(rst), .en_i(en), .btn_i(btn_add), .pulse_o(add_pulse)
  );
  button_pulse #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_clr (
    .clk_1khz(clk_1khz), .rst(rst), .en_i(en), .btn_i(btn_clr), .pulse_o(clr_pulse)
  );

  state_e               state_q;
  state_e               state_d;
  logic                 editing_q;
  logic [IDX_W-1:0]     sel_q;
  logic [4:0]           hr_q  [NUM_ALARMS];
  logic [5:0]           min_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_hidden_q;

  assign state_d = next_mode(state_q);

  // Editor FSM, alarm storage and blink timer share one clocked process.
  // Priority within a cycle: mode, then clr, then add.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      editing_q      <= 1'b0;
      sel_q          <= '0;
      en_q           <= '0;
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        hr_q[k]  <= '0;
        min_q[k] <= '0;
      end
    end else if (en) begin
      if (mode_pulse) begin
        state_q   <= state_d;
        editing_q <= (state_d != S_IDLE);
      end else if (clr_pulse) begin
        case (state_q)
          S_SEL:     sel_q         <= '0;
          S_SET_HR:  hr_q[sel_q]   <= '0;
          S_SET_MIN: min_q[sel_q]  <= '0;
          S_SET_EN:  en_q[sel_q]   <= 1'b0;
          default:   ;
        endcase
      end else if (add_pulse) begin
        case (state_q)
          S_SEL:
            sel_q <= (sel_q == IDX_W'(NUM_ALARMS - 1)) ? '0 : sel_q + IDX_W'(1);
          S_SET_HR:
            hr_q[sel_q] <= (hr_q[sel_q] == 5'(HR_MOD - 1)) ? '0 : hr_q[sel_q] + 5'd1;
          S_SET_MIN:
            min_q[sel_q] <= (min_q[sel_q] == 6'(MIN_MOD - 1)) ? '0 : min_q[sel_q] + 6'd1;
          S_SET_EN:
            en_q[sel_q] <= ~en_q[sel_q];
          default: ;
        endcase
      end

      // Any user action restarts the blink so the new value is seen at once.
      if (mode_pulse || add_pulse || clr_pulse || state_q == S_IDLE) begin
        blink_cnt_q    <= '0;
        blink_hidden_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt_q    <= '0;
        blink_hidden_q <= ~blink_hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Display of the selected alarm, with the edited field blanked when hidden.
  logic [7:0] sel_hr_bcd, sel_min_bcd;
  logic       blank;

  always_comb begin
    sel_hr_bcd  = bin2bcd({2'b00, hr_q[sel_q]});
    sel_min_bcd = bin2bcd({1'b0, min_q[sel_q]});
    blank       = blink_hidden_q && en && (state_q != S_IDLE);
    display_out = {sel_hr_bcd, SEP_NIBBLE, sel_min_bcd, SEP_NIBBLE,
                   4'(sel_q), {3'b000, en_q[sel_q]}};
    if (blank) begin
      case (state_q)
        S_SEL:     display_out[7:4]   = BLANK_NIBBLE;
        S_SET_HR:  display_out[31:24] = {BLANK_NIBBLE, BLANK_NIBBLE};
        S_SET_MIN: display_out[19:12] = {BLANK_NIBBLE, BLANK_NIBBLE};
        S_SET_EN:  display_out[3:0]   = BLANK_NIBBLE;
        default:   ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm_bcd
    assign alarm_bcd_out[16*k +: 16] = {bin2bcd({2'b00, hr_q[k]}), bin2bcd({1'b0, min_q[k]})};
  end

  assign alarm_en_out = en_q;
  assign editing      = editing_q;

endmodule

// File: tb/tb_alarm_set_multi.sv
// Directed bench for alarm_set_multi with DEBOUNCE_MS=2, BLINK_MS=4,
// NUM_ALARMS=4. Inputs change on the falling clock edge, outputs are
// sampled on the falling edge as well.
module tb_alarm_set_multi;
  import alarm_pkg::*;

  localparam int NA = 4;

  logic              clk_1khz = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              btn_mode = 1'b0;
  logic              btn_add = 1'b0;
  logic              btn_clr = 1'b0;
  logic [31:0]       display_out;
  logic [16*NA-1:0]  alarm_bcd_out;
  logic [NA-1:0]     alarm_en_out;
  logic              editing;

  int total = 0;
  int bad   = 0;

  alarm_set_multi #(.NUM_ALARMS(NA), .BLINK_MS(4), .DEBOUNCE_MS(2)) dut (
    .clk_1khz(clk_1khz), .rst(rst), .en(en),
    .btn_mode(btn_mode), .btn_add(btn_add), .btn_clr(btn_clr),
    .display_out(display_out), .alarm_bcd_out(alarm_bcd_out),
    .alarm_en_out(alarm_en_out), .editing(editing)
  );

  // clock / reset
  always #5 clk_1khz = ~clk_1khz;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = mode, 1 = add, 2 = clr. Held 6 cycles, released 6 cycles; the
  // debounced pulse is consumed on the fifth rising edge after the press.
  task automatic press(input int which);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_add  = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    repeat (6) @(negedge clk_1khz);
    btn_mode = 1'b0;
    btn_add  = 1'b0;
    btn_clr  = 1'b0;
    repeat (6) @(negedge clk_1khz);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk_1khz);
    rst = 1'b0;
    @(negedge clk_1khz);
    check("rst_display", 64'(display_out), 64'h00E00E00);
    check("rst_bcd", 64'(alarm_bcd_out), 64'h0);
    check("rst_en", 64'(alarm_en_out), 64'h0);
    check("rst_editing", 64'(editing), 64'h0);

    // into S_SET_HR on alarm 0
    press(0);
    check("editing_sel", 64'(editing), 64'h1);
    press(0);
    check("state_hr", 64'(dut.state_q), 64'(S_SET_HR));

    // one-cycle glitch is rejected
    btn_add = 1'b1;
    @(negedge clk_1khz);
    btn_add = 1'b0;
    repeat (8) @(negedge clk_1khz);
    check("glitch_hr", 64'(alarm_bcd_out[15:0]), 64'h0000);

    // five-cycle hold gives exactly one increment
    btn_add = 1'b1;
    repeat (5) @(negedge clk_1khz);
    btn_add = 1'b0;
    repeat (8) @(negedge clk_1khz);
    check("hold_hr", 64'(alarm_bcd_out[15:0]), 64'h0100);

    // back to idle, select alarm 2 and edit it with wrap-arounds
    press_n(0, 3);
    check("idle_again", 64'(editing), 64'h0);
    press(0);
    press_n(1, 2);
    press(0);
    press_n(1, 25);
    press(0);
    press_n(1, 61);
    press(0);
    press(1);
    press(0);
    check("a2_display", 64'(display_out), 64'h01E01E21);
    check("a2_bcd", 64'(alarm_bcd_out[47:32]), 64'h0101);
    check("a2_en", 64'(alarm_en_out), 64'b0100);
    check("a0_kept", 64'(alarm_bcd_out[15:0]), 64'h0100);
    check("a1_kept", 64'(alarm_bcd_out[31:16]), 64'h0000);
    check("a3_kept", 64'(alarm_bcd_out[63:48]), 64'h0000);
    check("a2_editing", 64'(editing), 64'h0);

    // blink of the minute field on alarm 2
    press_n(0, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_1khz);
      check($sformatf("blink_%0d", i), 64'(display_out[19:12]), (i < 4) ? 64'h01 : 64'hFF);
    end
    // an add restarts the blink as visible
    btn_add = 1'b1;
    repeat (5) @(negedge clk_1khz);
    check("restart_vis0", 64'(display_out[19:12]), 64'h02);
    @(negedge clk_1khz);
    btn_add = 1'b0;
    repeat (2) @(negedge clk_1khz);
    check("restart_vis3", 64'(display_out[19:12]), 64'h02);
    @(negedge clk_1khz);
    check("restart_hid", 64'(display_out[19:12]), 64'hFF);
    repeat (6) @(negedge clk_1khz);

    // mode and add together from S_SEL: mode wins
    press_n(0, 3);
    btn_mode = 1'b1;
    btn_add  = 1'b1;
    repeat (6) @(negedge clk_1khz);
    btn_mode = 1'b0;
    btn_add  = 1'b0;
    repeat (6) @(negedge clk_1khz);
    check("simul_state", 64'(dut.state_q), 64'(S_SET_HR));
    check("simul_sel", 64'(display_out[7:0]), 64'h21);
    check("simul_a2", 64'(alarm_bcd_out[47:32]), 64'h0102);

    // enable low: mode press ignored, display unblanked
    en = 1'b0;
    press(0);
    check("en0_state", 64'(dut.state_q), 64'(S_SET_HR));
    check("en0_display", 64'(display_out), 64'h01E02E21);
    en = 1'b1;
    @(negedge clk_1khz);

    // alarm 1 to 07:30 (clr used to reset the index)
    press_n(0, 4);
    press(2);
    press(1);
    press(0);
    press_n(1, 7);
    press(0);
    press_n(1, 30);
    check("a1_0730", 64'(alarm_bcd_out[31:16]), 64'h0730);
    check("a1_state", 64'(dut.state_q), 64'(S_SET_MIN));

    // asynchronous reset mid-edit
    rst = 1'b1;
    #1;
    check("mid_rst_bcd", 64'(alarm_bcd_out), 64'h0);
    check("mid_rst_en", 64'(alarm_en_out), 64'h0);
    check("mid_rst_editing", 64'(editing), 64'h0);
    check("mid_rst_display", 64'(display_out), 64'h00E00E00);
    check("mid_rst_state", 64'(dut.state_q), 64'(S_IDLE));
    @(negedge clk_1khz);
    rst = 1'b0;
    repeat (2) @(negedge clk_1khz);
    check("post_rst_display", 64'(display_out), 64'h00E00E00);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_set_multi.md
Name: alarm_set_multi

Overview:
- Multi-channel alarm editor, successor to the single-alarm setter.
- Holds NUM_ALARMS alarm times (HH:MM) plus a per-alarm enable flag.
- Edited with three push buttons through an IDLE/SEL/HR/MIN/EN state machine. Buttons are synchronised and debounced inside the block, fully synchronous to clk_1khz.
- Drives an 8-nibble display bus, with blinking on the field being edited, and a packed BCD alarm bus to the alarm comparator.

Parameters:
- NUM_ALARMS, 4, number of alarm channels, 1..8.
- BLINK_MS, 300, half-period of the edit-field blink, in clk_1khz cycles.
- DEBOUNCE_MS, 20, cycles a synchronised button must be stable before its level is accepted.
- Localparam IDX_W = max(1, clog2(NUM_ALARMS)).

Ports:
- clk_1khz  in  1  system clock, 1 kHz.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  block enable; when low, all state, counters and values hold.
- btn_mode  in  1  raw button; advances the edit state.
- btn_add  in  1  raw button; increments the field being edited.
- btn_clr  in  1  raw button; zeroes the field being edited.
- display_out  out  32  8 BCD nibbles for the display driver.
- alarm_bcd_out  out  16*NUM_ALARMS  per alarm, {hr_t, hr_o, min_t, min_o}; alarm k occupies bits [16k+15:16k].
- alarm_en_out  out  NUM_ALARMS  per-alarm enable flags.
- editing  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset values (asynchronous): state S_IDLE; sel index 0; all hr=0, min=0; all enables 0; blink counter 0; blink phase visible. Outputs therefore: display_out = 32'h00E00E00 (alarm 0, 00:00, disabled); alarm_bcd_out all 0; alarm_en_out all 0; editing 0.
- Button path:
  - 2-FF synchroniser.
  - Debounced level changes only after DEBOUNCE_MS consecutive equal synchronised samples.
  - A single-cycle pulse is generated on the 0->1 transition of the debounced level.
  - Registered values update on the cycle after the pulse.
- State encoding: S_IDLE, S_SEL, S_SET_HR, S_SET_MIN, S_SET_EN.
- mode pulse transitions: S_IDLE->S_SEL->S_SET_HR->S_SET_MIN->S_SET_EN->S_IDLE.
- add pulse, by state:
  - S_IDLE: no effect.
  - S_SEL: sel index +1; wraps NUM_ALARMS-1 -> 0.
  - S_SET_HR: hr[sel] +1; wraps 23 -> 0.
  - S_SET_MIN: min[sel] +1; wraps 59 -> 0.
  - S_SET_EN: toggles en[sel].
- clr pulse, by state:
  - S_SEL: index -> 0.
  - S_SET_HR: hr -> 0.
  - S_SET_MIN: min -> 0.
  - S_SET_EN: en -> 0.
  - S_IDLE: no effect.
- Simultaneous pulses in the same cycle: mode has highest priority; add and clr are ignored. If add and clr coincide, clr wins.
- Storage is binary (5-bit hr, 6-bit min). BCD conversion is combinational at the outputs. Values are never out of range.
- Blink:
  - Counter runs 0..BLINK_MS-1 only when editing && en; the phase toggles at wrap.
  - Any state change, or any add/clr pulse, resets the counter to 0 and the phase to visible.
  - In S_IDLE the phase is forced to visible.
- display_out layout, nibbles [31:28]..[3:0]: hr_t, hr_o, E, min_t, min_o, E, sel index (0-based), en[sel] (0/1). E is 4'hE, the separator.
- Blanking: during the hidden phase the active field's nibbles are forced to 4'hF (blank code).
  - S_SEL: nibble [7:4].
  - S_SET_HR: [31:24].
  - S_SET_MIN: [19:12].
  - S_SET_EN: [3:0].
- en low: pulses are discarded (not queued); debounce, synchroniser and blink counters hold; display shows unblanked values.
- rst asserted mid-edit: immediate return to the reset values; edits in progress are lost.

Decomposition:
- Shared package (alarm_pkg): state encodings; SEP_NIBBLE=4'hE; BLANK_NIBBLE=4'hF; HR_MOD=24; MIN_MOD=60; binary-to-2-digit-BCD function.
- One sub-module, button_pulse (sync + debounce + rising-edge pulse, parameter DEBOUNCE_MS), instantiated three times.

Test Plan (bench uses DEBOUNCE_MS=2, BLINK_MS=4, NUM_ALARMS=4):
- rst pulse -> display_out=32'h00E00E00, alarm_bcd_out=0, alarm_en_out=0, editing=0.
- Glitch btn_add high for 1 cycle in S_SET_HR -> hr unchanged. Hold high 5 cycles -> hr=1, exactly one increment.
- Select alarm 2; in S_SET_HR press add 25 times; in S_SET_MIN press add 61 times; in S_SET_EN press add once; then mode -> alarm_bcd_out[47:32]=16'h0101, alarm_en_out=4'b0100, display_out=32'h01E01E21. Alarms 0, 1 and 3 unchanged.
- In S_SET_MIN, observe 8 idle cycles -> [19:12] alternates 4'hFF / value every 4 cycles. A single add restarts the phase as visible.
- btn_mode and btn_add pulses in the same cycle from S_SEL -> state S_SET_HR, index unchanged. With en=0, press mode -> state unchanged.
- Set alarm 1 to 07:30, then assert rst in S_SET_MIN -> all alarms 00:00, state S_IDLE, sel=0.
